// File: rtl/core_fetch_redirect_unit_pkg.sv
// Shared types and constants for the fetch/redirect unit: FSM state encoding,
// instruction size and the redirect-target alignment test.
package core_fetch_redirect_unit_pkg;

    localparam int FETCH_ST_WIDTH = 2;
    localparam int INSTR_BYTES    = 4;

    typedef enum logic [FETCH_ST_WIDTH-1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/core_fetch_redirect_unit_if.sv
// Fetch unit bundle: execute redirect inputs, instruction-memory req/gnt/rvalid
// port and the decode-side valid/ready handshake.
interface core_fetch_redirect_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ex_valid_i;
    logic                  branch_i;
    logic                  jump_i;
    logic [DATA_WIDTH-1:0] brj_pc_i;

    logic                  imem_req_o;
    logic [DATA_WIDTH-1:0] imem_addr_o;
    logic                  imem_gnt_i;
    logic                  imem_rvalid_i;
    logic [DATA_WIDTH-1:0] imem_rdata_i;

    logic [DATA_WIDTH-1:0] instr_o;
    logic [DATA_WIDTH-1:0] instr_pc_o;
    logic                  instr_valid_o;
    logic                  instr_ready_i;

    logic                  flush_o;
    logic                  misalign_o;

    // The fetch unit itself.
    modport master (
        input  ex_valid_i, branch_i, jump_i, brj_pc_i,
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output instr_o, instr_pc_o, instr_valid_o,
        input  instr_ready_i,
        output flush_o, misalign_o
    );

    // Its environment: execute stage, instruction memory and decode.
    modport slave (
        output ex_valid_i, branch_i, jump_i, brj_pc_i,
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  instr_o, instr_pc_o, instr_valid_o,
        output instr_ready_i,
        input  flush_o, misalign_o
    );

endinterface

// File: rtl/core_fetch_buffer.sv
// Single-entry instruction buffer between fetch and decode. Clear beats load,
// load beats pop.
module core_fetch_buffer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  load,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] instr_d,
    input  logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  valid
);

    // NOTE: this is one register entry, not a RAM, so its data is reset along
    // with the flag and decode never sees X even when valid is low.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            instr <= '0;
            pc    <= '0;
            valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values regardless of statement order.
            if (load) begin
                instr <= instr_d;
                pc    <= pc_d;
            end
            if (clear)     valid <= 1'b0;
            else if (load) valid <= 1'b1;
            else if (pop)  valid <= 1'b0;
        end
    end

endmodule

// File: rtl/core_fetch_redirect_unit.sv
// Fetch-side PC and instruction-fetch controller: sequences PC+4 fetches with
// one outstanding request and applies taken branch/jump redirects from execute.
module core_fetch_redirect_unit
    import core_fetch_redirect_unit_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input logic                   clk_i,
    input logic                   rstn_i,
    core_fetch_redirect_unit_if.master bus
);

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, fpc_q;
    logic                  drop_q, flush_q, misalign_q;

    logic                  redir, redir_ok, redir_bad;
    logic                  grant, resp;
    logic                  buf_load, buf_pop, buf_valid;
    logic [DATA_WIDTH-1:0] buf_instr, buf_pc;

    assign redir     = bus.ex_valid_i & (bus.branch_i | bus.jump_i);
    assign redir_ok  = redir &  is_word_aligned(bus.brj_pc_i[1:0]);
    assign redir_bad = redir & ~is_word_aligned(bus.brj_pc_i[1:0]);

    assign grant    = (state_q == FETCH_REQ)  & bus.imem_gnt_i;
    assign resp     = (state_q == FETCH_WAIT) & bus.imem_rvalid_i;
    assign buf_load = resp & ~drop_q & ~redir_ok;
    assign buf_pop  = (state_q == FETCH_HOLD) & buf_valid & bus.instr_ready_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= FETCH_BOOT;
        else         state_q <= state_d;
    end

    // A redirect in REQ lands in the same state as the normal path (the stale
    // grant is killed via drop_q); in WAIT/HOLD it forces a fresh request.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        case (state_q)
            FETCH_BOOT: state_d = FETCH_REQ;
            FETCH_REQ:  if (grant) state_d = FETCH_WAIT;
            FETCH_WAIT: if (resp)  state_d = (drop_q | redir_ok) ? FETCH_REQ : FETCH_HOLD;
            FETCH_HOLD: if (redir_ok | buf_pop) state_d = FETCH_REQ;
        endcase
    end

    always_comb begin
        bus.imem_req_o = 1'b0;
        case (state_q)
            FETCH_REQ: bus.imem_req_o = 1'b1;
            default:   bus.imem_req_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q       <= BOOT_ADDR;
            fpc_q      <= '0;
            drop_q     <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (redir_ok)   pc_q <= bus.brj_pc_i;
            else if (grant) pc_q <= pc_q + DATA_WIDTH'(INSTR_BYTES);

            if (grant) fpc_q <= pc_q;

            // Any response retires the single outstanding fetch; a redirect
            // with a fetch still in flight marks that fetch as wrong-path.
            if (resp)
                drop_q <= 1'b0;
            else if (redir_ok & (grant | (state_q == FETCH_WAIT)))
                drop_q <= 1'b1;

            flush_q    <= redir_ok;
            misalign_q <= redir_bad;
        end
    end

    core_fetch_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buffer (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .load    (buf_load),
        .pop     (buf_pop),
        .clear   (redir_ok),
        .instr_d (bus.imem_rdata_i),
        .pc_d    (fpc_q),
        .instr   (buf_instr),
        .pc      (buf_pc),
        .valid   (buf_valid)
    );

    assign bus.imem_addr_o   = pc_q;
    assign bus.instr_o       = buf_instr;
    assign bus.instr_pc_o    = buf_pc;
    assign bus.instr_valid_o = buf_valid;
    assign bus.flush_o       = flush_q;
    assign bus.misalign_o    = misalign_q;

endmodule

// File: tb/tb_core_fetch_redirect_unit.sv
// Scoreboard bench: the expected decode stream is "target, target+4, ..." restarted
// on every aligned redirect; a negedge monitor pops it on each decode transfer.
module tb_core_fetch_redirect_unit;

    localparam int          DW   = 32;
    localparam logic [31:0] BOOT = 32'h0000_0100;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    core_fetch_redirect_unit_if #(.DATA_WIDTH(DW)) bus ();

    core_fetch_redirect_unit #(
        .DATA_WIDTH (DW),
        .BOOT_ADDR  (BOOT)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;

    exp_t        exp_q[$];
    logic [31:0] next_push_pc;
    logic [31:0] exp_gnt_addr;
    logic        prev_ok  = 1'b0;
    logic        prev_bad = 1'b0;

    // instruction-memory model state and knobs
    int          gnt_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    logic        mem_pending = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    endtask

    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(exp_t'{pc: next_push_pc, instr: mem_word(next_push_pc)});
            next_push_pc += 32'd4;
        end
    endtask

    task automatic restart_model(input logic [31:0] addr);
        exp_q.delete();
        next_push_pc = addr;
        refill();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        refill();
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic use_jump);
        bus.ex_valid_i = 1'b1;
        bus.branch_i   = ~use_jump;
        bus.jump_i     = use_jump;
        bus.brj_pc_i   = tgt;
        if (tgt[1:0] == 2'b00) restart_model(tgt);
        step();
        bus.ex_valid_i = 1'b0;
        bus.branch_i   = 1'b0;
        bus.jump_i     = 1'b0;
        bus.brj_pc_i   = $urandom;
    endtask

    task automatic do_reset();
        rstn        = 1'b0;
        mem_pending = 1'b0;
        restart_model(BOOT);
        exp_gnt_addr = BOOT;
        #1;
        check("rst_req",      32'(bus.imem_req_o),    32'd0);
        check("rst_addr",     bus.imem_addr_o,        BOOT);
        check("rst_valid",    32'(bus.instr_valid_o), 32'd0);
        check("rst_instr",    bus.instr_o,            32'd0);
        check("rst_ipc",      bus.instr_pc_o,         32'd0);
        check("rst_flush",    32'(bus.flush_o),       32'd0);
        check("rst_misalign", 32'(bus.misalign_o),    32'd0);
        step();
        step();
        rstn = 1'b1;
        check("boot_cycle_req", 32'(bus.imem_req_o), 32'd0);
        step();
        check("first_req",      32'(bus.imem_req_o), 32'd1);
        check("first_req_addr", bus.imem_addr_o,     BOOT);
    endtask

    // memory response driver: one rvalid per grant, lat cycles after the grant cycle + 1
    always @(posedge clk) begin
        #1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = $urandom;
        if (mem_pending) begin
            if (mem_cnt == 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = mem_word(mem_addr);
                mem_pending       = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        bus.imem_gnt_i = ($urandom_range(99) < gnt_pct);
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic redir_now, ok_now, bad_now;
        exp_t e;
        if (!rstn) begin
            prev_ok  = 1'b0;
            prev_bad = 1'b0;
        end else begin
            redir_now = bus.ex_valid_i & (bus.branch_i | bus.jump_i);
            ok_now    = redir_now & (bus.brj_pc_i[1:0] == 2'b00);
            bad_now   = redir_now & (bus.brj_pc_i[1:0] != 2'b00);

            check("flush_pulse",    32'(bus.flush_o),    32'(prev_ok));
            check("misalign_pulse", 32'(bus.misalign_o), 32'(prev_bad));

            if (bus.instr_valid_o && bus.instr_ready_i && !ok_now) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL xfer_unexpected: actual pc %h required none", bus.instr_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_pc",    bus.instr_pc_o, e.pc);
                    check("xfer_instr", bus.instr_o,    e.instr);
                    n_xfer++;
                end
            end

            if (bus.imem_req_o && bus.imem_gnt_i) begin
                if (!ok_now) begin
                    check("gnt_addr", bus.imem_addr_o, exp_gnt_addr);
                    exp_gnt_addr += 32'd4;
                end
                mem_pending = 1'b1;
                mem_addr    = bus.imem_addr_o;
                mem_cnt     = int'($urandom_range(lat_max, lat_min));
            end
            if (ok_now) exp_gnt_addr = bus.brj_pc_i;

            prev_ok  = ok_now;
            prev_bad = bad_now;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int budget;
        int r;
        bus.ex_valid_i    = 1'b0;
        bus.branch_i      = 1'b0;
        bus.jump_i        = 1'b0;
        bus.brj_pc_i      = '0;
        bus.instr_ready_i = 1'b1;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;

        // straight-line fetch from BOOT with 1-cycle memory
        step();
        do_reset();
        repeat (12) step();

        // decode stalls on the first word
        bus.instr_ready_i = 1'b0;
        do_reset();
        budget = 20;
        while (!bus.instr_valid_o && budget > 0) begin step(); budget--; end
        check("stall_wait_valid", 32'(bus.instr_valid_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(bus.instr_valid_o), 32'd1);
            check("stall_pc",    bus.instr_pc_o,         BOOT);
            check("stall_noreq", 32'(bus.imem_req_o),    32'd0);
            step();
        end
        bus.instr_ready_i = 1'b1;
        repeat (6) step();

        // redirect while a fetch is in WAIT, response two cycles later
        lat_min = 2;
        lat_max = 2;
        step();
        budget = 20;
        while (!bus.imem_req_o && budget > 0) begin step(); budget--; end
        check("wait_req_seen", 32'(bus.imem_req_o), 32'd1);
        step();
        redirect(32'h0000_0200, 1'b0);
        repeat (15) step();

        // redirect coinciding with the grant for 0x104
        lat_min = 0;
        lat_max = 0;
        do_reset();
        budget = 20;
        while (!(bus.imem_req_o && bus.imem_addr_o == 32'h104) && budget > 0) begin
            step();
            budget--;
        end
        check("req_104_seen", bus.imem_addr_o, 32'h0000_0104);
        redirect(32'h0000_0300, 1'b1);
        repeat (12) step();

        // misaligned target: pulse only, stream continues
        redirect(32'h0000_0402, 1'b0);
        repeat (10) step();

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFF8, 1'b1);
        repeat (15) step();

        // randomized traffic
        gnt_pct = 60;
        lat_max = 3;
        for (int c = 0; c < 3000; c++) begin
            bus.instr_ready_i = ($urandom_range(3) != 0);
            r = int'($urandom_range(99));
            if (r < 4)
                redirect(($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                  : ($urandom & 32'hFFFF_FFFC), $urandom_range(1) == 1);
            else if (r < 5)
                redirect(($urandom & 32'hFFFF_FFFC) | 32'(1 + $urandom_range(2)), $urandom_range(1) == 1);
            else if (r < 7) begin
                bus.branch_i = 1'b1;
                bus.jump_i   = $urandom_range(1) == 1;
                bus.brj_pc_i = $urandom & 32'hFFFF_FFFC;
                step();
                bus.branch_i = 1'b0;
                bus.jump_i   = 1'b0;
            end else
                step();
        end
        bus.instr_ready_i = 1'b1;
        repeat (20) step();

        check("progress", 32'(n_xfer >= 100), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
